disp_wr_arb: RTL and testbench

Arbiter for the shared display-memory write port. Up to three producers (error-counter telemetry, game-board renderer, score/status logic) each emit unthrottled single-cycle write strobes as flag/addr/data. Each stream is buffered in a small per-requester FIFO. The FIFOs are drained onto the single downstream write port at most one write per cycle, honouring a downstream ready.

---
 rtl/disp_wr_arb.sv | 139 +++++++++++++
 tb/tb_disp_wr_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_wr_arb.sv
// Display-memory write arbiter: three buffered single-strobe producers share one registered write port.
// Optional DISP_ARB_PRIO_EN gives requester 0 strict priority; default build is plain 3-way round-robin.
module disp_wr_arb #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flag0,
    input  logic              i_flag1,
    input  logic              i_flag2,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic              i_ready,
    input  logic              i_ovf_clr,
    output logic              o_flag,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_src,
    output logic [2:0]        o_ovf,
    output logic              o_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]     mem_q [3][DEPTH];
    logic [EW-1:0]     mem_d [3][DEPTH];
    logic [PW-1:0]     wr_ptr_q [3];
    logic [PW-1:0]     wr_ptr_d [3];
    logic [PW-1:0]     rd_ptr_q [3];
    logic [PW-1:0]     rd_ptr_d [3];
    logic [CW-1:0]     cnt_q [3];
    logic [CW-1:0]     cnt_d [3];
    logic [1:0]        last_q, last_d;
    logic              flag_q, flag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        src_q, src_d;
    logic [2:0]        ovf_q, ovf_d;
    logic              busy_q, busy_d;

    logic [2:0]        in_flag, nonempty, pop, accept, drop;
    logic [EW-1:0]     in_ent [3];
    logic [EW-1:0]     sel_ent;
    logic              grant;
    logic [1:0]        win;

    always_comb begin
        in_flag   = {i_flag2, i_flag1, i_flag0};
        in_ent[0] = {i_addr0, i_data0};
        in_ent[1] = {i_addr1, i_data1};
        in_ent[2] = {i_addr2, i_data2};
        for (int i = 0; i < 3; i++) nonempty[i] = (cnt_q[i] != '0);
        grant = i_ready && (nonempty != 3'b000);

`ifdef DISP_ARB_PRIO_EN
        // last_q only ever holds 1 or 2 here; it decides which of 1/2 goes first
        if (nonempty[0])          win = 2'd0;
        else if (last_q == 2'd2)  win = nonempty[1] ? 2'd1 : 2'd2;
        else                      win = nonempty[2] ? 2'd2 : 2'd1;
        last_d = (grant && win != 2'd0) ? win : last_q;
`else
        case (last_q)
            2'd0:    win = nonempty[1] ? 2'd1 : (nonempty[2] ? 2'd2 : 2'd0);
            2'd1:    win = nonempty[2] ? 2'd2 : (nonempty[0] ? 2'd0 : 2'd1);
            default: win = nonempty[0] ? 2'd0 : (nonempty[1] ? 2'd1 : 2'd2);
        endcase
        last_d = grant ? win : last_q;
`endif
        pop = grant ? (3'b001 << win) : 3'b000;

        // a full FIFO can still take a push when it is popped in the same cycle
        mem_d = mem_q;
        for (int i = 0; i < 3; i++) begin
            accept[i]   = in_flag[i] && ((cnt_q[i] != FULL) || pop[i]);
            drop[i]     = in_flag[i] && !accept[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (accept[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_ent[i];
                wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            cnt_d[i] = cnt_q[i] + {{(CW-1){1'b0}}, accept[i]} - {{(CW-1){1'b0}}, pop[i]};
        end

        ovf_d   = (i_ovf_clr ? 3'b000 : ovf_q) | drop;
        sel_ent = mem_q[win][rd_ptr_q[win]];
        flag_d  = grant;
        addr_d  = grant ? sel_ent[EW-1:DATA_W] : '0;
        data_d  = grant ? sel_ent[DATA_W-1:0] : '0;
        src_d   = grant ? win : 2'd0;
        busy_d  = grant || (cnt_d[0] != '0) || (cnt_d[1] != '0) || (cnt_d[2] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            last_q   <= 2'd2;
            flag_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            src_q    <= 2'd0;
            ovf_q    <= 3'b000;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            flag_q   <= flag_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_flag = flag_q;
    assign o_addr = addr_q;
    assign o_data = data_q;
    assign o_src  = src_q;
    assign o_ovf  = ovf_q;
    assign o_busy = busy_q;
endmodule

// File: tb/tb_disp_wr_arb.sv
// Bench for disp_wr_arb: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_disp_wr_arb;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        flg;
    logic [ADDR_W-1:0] adr [3];
    logic [DATA_W-1:0] dat [3];
    logic              i_ready = 1'b0;
    logic              i_ovf_clr = 1'b0;
    logic              o_flag;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_src;
    logic [2:0]        o_ovf;
    logic              o_busy;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    disp_wr_arb #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .i_flag0(flg[0]), .i_flag1(flg[1]), .i_flag2(flg[2]),
        .i_addr0(adr[0]), .i_addr1(adr[1]), .i_addr2(adr[2]),
        .i_data0(dat[0]), .i_data1(dat[1]), .i_data2(dat[2]),
        .i_ready(i_ready), .i_ovf_clr(i_ovf_clr),
        .o_flag(o_flag), .o_addr(o_addr), .o_data(o_data),
        .o_src(o_src), .o_ovf(o_ovf), .o_busy(o_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // reference model: one queue per requester, arbitration by scanning from last winner
    logic [ADDR_W+DATA_W-1:0] mq [3][$];
    logic [ADDR_W+DATA_W-1:0] tmp;
    int          m_last = 2;
    int          w;
    logic        started = 1'b0;
    logic        e_flag = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_data = '0;
    logic [1:0]  e_src = 2'd0;
    logic [2:0]  e_ovf = 3'b000;
    logic        e_busy = 1'b0;

    function automatic int pick();
`ifdef DISP_ARB_PRIO_EN
        int a;
        if (mq[0].size() != 0) return 0;
        a = (m_last == 1) ? 2 : 1;
        if (mq[a].size() != 0) return a;
        if (mq[3-a].size() != 0) return 3 - a;
        return -1;
`else
        for (int k = 1; k <= 3; k++)
            if (mq[(m_last + k) % 3].size() != 0) return (m_last + k) % 3;
        return -1;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) mq[n].delete();
            m_last = 2;
            e_flag = 1'b0; e_addr = '0; e_data = '0; e_src = 2'd0; e_ovf = 3'b000; e_busy = 1'b0;
            started = 1'b1;
        end else begin
            w = i_ready ? pick() : -1;
            if (w >= 0) begin
                tmp = mq[w].pop_front();
                e_flag = 1'b1;
                e_addr = tmp[ADDR_W+DATA_W-1:DATA_W];
                e_data = tmp[DATA_W-1:0];
                e_src  = 2'(w);
`ifdef DISP_ARB_PRIO_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
            end else begin
                e_flag = 1'b0; e_addr = '0; e_data = '0; e_src = 2'd0;
            end
            if (i_ovf_clr) e_ovf = 3'b000;
            for (int n = 0; n < 3; n++) begin
                if (flg[n]) begin
                    if (mq[n].size() < DEPTH) mq[n].push_back({adr[n], dat[n]});
                    else e_ovf[n] = 1'b1;
                end
            end
            e_busy = e_flag || (mq[0].size() + mq[1].size() + mq[2].size() != 0);
        end
        #1;
        if (started) begin
            chk("cyc_o_flag", o_flag, e_flag);
            chk("cyc_o_addr", o_addr, e_addr);
            chk("cyc_o_data", o_data, e_data);
            chk("cyc_o_src",  o_src,  e_src);
            chk("cyc_o_ovf",  o_ovf,  e_ovf);
            chk("cyc_o_busy", o_busy, e_busy);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr_in();
        flg = 3'b000;
        i_ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        step();
        rst = 1'b0;
    endtask

`ifdef DISP_ARB_PRIO_EN
    int fair_exp [6] = '{0, 0, 1, 2, 1, 2};
`else
    int fair_exp [6] = '{0, 1, 2, 0, 1, 2};
`endif
    int ready_pct;

    initial begin
        flg = 3'b000;
        for (int n = 0; n < 3; n++) begin adr[n] = '0; dat[n] = '0; end
        step(); step();
        rst = 1'b0;
        chk("rst_flag", o_flag, 0);
        chk("rst_busy", o_busy, 0);

        // single write on requester 1: visible exactly two cycles later
        flg[1] = 1'b1; adr[1] = 7'd100; dat[1] = 4'hA; i_ready = 1'b1;
        step(); clr_in();
        chk("single_c1_flag", o_flag, 0);
        step();
        chk("single_flag", o_flag, 1);
        chk("single_addr", o_addr, 100);
        chk("single_data", o_data, 4'hA);
        chk("single_src",  o_src, 1);
        step();
        chk("single_after_flag", o_flag, 0);
        chk("single_after_busy", o_busy, 0);

        // fairness with two entries queued per requester
        do_reset(); i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            flg = 3'b111;
            for (int n = 0; n < 3; n++) begin adr[n] = 7'(n * 10 + k); dat[n] = 4'(k); end
            step();
        end
        clr_in(); i_ready = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair_src%0d", k), o_src, fair_exp[k]);
            chk($sformatf("fair_flag%0d", k), o_flag, 1);
            step();
        end

        // overflow: five pushes into a depth-4 FIFO with no drain
        do_reset(); i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            flg[2] = 1'b1; adr[2] = 7'(10 + k); dat[2] = 4'(k);
            step();
        end
        clr_in();
        chk("ovf_set", o_ovf, 3'b100);
        i_ready = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_drain_data%0d", k), o_data, k);
            chk($sformatf("ovf_drain_addr%0d", k), o_addr, 10 + k);
            step();
        end
        chk("ovf_fifth_dropped", o_flag, 0);
        chk("ovf_sticky", o_ovf, 3'b100);
        i_ovf_clr = 1'b1;
        step(); i_ovf_clr = 1'b0;
        chk("ovf_cleared", o_ovf, 3'b000);

        // full FIFO with push and pop in the same cycle
        do_reset(); i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            flg[0] = 1'b1; adr[0] = 7'(20 + k); dat[0] = 4'(k);
            step();
        end
        i_ready = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            flg[0] = 1'b1; adr[0] = 7'(20 + k); dat[0] = 4'(k);
            step();
            chk($sformatf("full_pp_data%0d", k - 4), o_data, k - 4);
        end
        clr_in();
        for (int k = 5; k <= 8; k++) begin
            step();
            chk($sformatf("full_pp_data%0d", k), o_data, k);
        end
        chk("full_pp_no_ovf", o_ovf, 3'b000);

        // backpressure
        do_reset(); i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flg[1] = 1'b1; adr[1] = 7'(40 + k); dat[1] = 4'(k);
            step();
        end
        clr_in();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_flag", o_flag, 0);
            chk("bp_busy", o_busy, 1);
        end
        i_ready = 1'b1;
        step();
        chk("bp_resume_flag", o_flag, 1);
        chk("bp_resume_addr", o_addr, 40);
        step(); step(); step();

        // reset while an entry is on the output and three are queued
        do_reset(); i_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            flg[0] = 1'b1; adr[0] = 7'(60 + k); dat[0] = 4'(k);
            step();
        end
        clr_in(); i_ready = 1'b1;
        step();
        chk("mid_rst_pre_flag", o_flag, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_flag", o_flag, 0);
        chk("mid_rst_addr", o_addr, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_src",  o_src, 0);
        chk("mid_rst_ovf",  o_ovf, 0);
        chk("mid_rst_busy", o_busy, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_rst_no_emit", o_flag, 0);
        end

        // randomized traffic, model-checked every cycle
        do_reset();
        for (int seg = 0; seg < 15; seg++) begin
            ready_pct = $urandom_range(20, 100);
            for (int c = 0; c < 100; c++) begin
                for (int n = 0; n < 3; n++) begin
                    flg[n] = ($urandom_range(0, 99) < 40);
                    adr[n] = ADDR_W'($urandom);
                    dat[n] = DATA_W'($urandom);
                end
                i_ready   = ($urandom_range(0, 99) < ready_pct);
                i_ovf_clr = ($urandom_range(0, 99) < 4);
                rst       = ($urandom_range(0, 999) < 5);
                step();
            end
        end
        rst = 1'b0; clr_in(); i_ready = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
